// File: rtl/ysyx_210247_wb_arbiter_if.sv
// Regfile write-port arbitration bus: WB-stage write, long-latency return beat,
// flush, registered regfile write port, pending/stall status and perf counter.
// Modports: slave = arbiter side, master = pipeline/environment side.
interface ysyx_210247_wb_arbiter_if #(
    parameter int XLEN = 64
);
    // WB stage write request and stall back to WB
    logic            wb_valid_i;
    logic            wb_wen_i;
    logic [4:0]      wb_wdest_i;
    logic [XLEN-1:0] wb_wdata_i;
    logic            wb_stall_o;
    // long-latency (mul/div) return beat, valid/ready
    logic            ll_valid_i;
    logic            ll_ready_o;
    logic [4:0]      ll_wdest_i;
    logic [XLEN-1:0] ll_wdata_i;
    // pipeline flush from WB
    logic            flush_i;
    // registered regfile write port
    logic            rf_wen_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    // status
    logic            ll_pending_o;
    logic [31:0]     perf_stall_cnt_o;

    modport slave (
        input  wb_valid_i, wb_wen_i, wb_wdest_i, wb_wdata_i,
        output wb_stall_o,
        input  ll_valid_i, ll_wdest_i, ll_wdata_i,
        output ll_ready_o,
        input  flush_i,
        output rf_wen_o, rf_waddr_o, rf_wdata_o,
        output ll_pending_o, perf_stall_cnt_o
    );

    modport master (
        output wb_valid_i, wb_wen_i, wb_wdest_i, wb_wdata_i,
        input  wb_stall_o,
        output ll_valid_i, ll_wdest_i, ll_wdata_i,
        input  ll_ready_o,
        output flush_i,
        input  rf_wen_o, rf_waddr_o, rf_wdata_o,
        input  ll_pending_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/ysyx_210247_wb_arbiter.sv
// Purpose: arbitrates the integer regfile write port between the WB stage and a
//          small FIFO of long-latency (mul/div) results, with a starvation limit.
// Latency: 1 cycle from winning request to registered rf_wen_o/rf_waddr_o/rf_wdata_o.
// Backpressure: ll_ready_o drops when the FIFO is full; wb_stall_o holds WB only
//          in forced-FIFO cycles. Ports: clk, rst (async active-low), bus (slave).
// Optional: define WB_ARB_PERF_EN to get a 32-bit stall-cycle counter on
//          perf_stall_cnt_o; otherwise that output is tied to 0.
module ysyx_210247_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_210247_wb_arbiter_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    // FIFO storage (data path only, no reset needed)
    logic [4:0]      fifo_dest [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve;

    logic            preq, freq, head_zero, freq_w;
    logic            force_fifo, fifo_gnt, pipe_gnt, bypass;
    logic            push, pop;
    logic            wen_nxt;
    logic [4:0]      waddr_nxt;
    logic [XLEN-1:0] wdata_nxt;
    logic [SW-1:0]   starve_nxt;

    always_comb begin
        preq      = bus.wb_valid_i & bus.wb_wen_i & (bus.wb_wdest_i != 5'd0);
        freq      = (count != '0);
        // An x0 head is discarded for free; it never competes for the port.
        head_zero = freq & (fifo_dest[rd_ptr] == 5'd0);
        freq_w    = freq & ~head_zero;

        force_fifo = freq_w & (starve == SW'(STARVE_MAX));
        fifo_gnt   = force_fifo | (~preq & freq_w);
        pipe_gnt   = preq & ~force_fifo;
        // Direct write only when nothing else wants the port and nothing is queued,
        // so a bypassed beat can never overtake a buffered one.
        bypass     = ~preq & ~freq & bus.ll_valid_i & ~bus.flush_i;

        pop  = fifo_gnt | head_zero;
        push = bus.ll_valid_i & bus.ll_ready_o & ~bypass;
    end

    always_comb begin
        wen_nxt   = 1'b0;
        waddr_nxt = fifo_dest[rd_ptr];
        wdata_nxt = fifo_data[rd_ptr];
        if (fifo_gnt) begin
            wen_nxt = 1'b1;
        end else if (pipe_gnt) begin
            wen_nxt   = 1'b1;
            waddr_nxt = bus.wb_wdest_i;
            wdata_nxt = bus.wb_wdata_i;
        end else if (bypass) begin
            wen_nxt   = (bus.ll_wdest_i != 5'd0);
            waddr_nxt = bus.ll_wdest_i;
            wdata_nxt = bus.ll_wdata_i;
        end
    end

    always_comb begin
        starve_nxt = starve;
        if (bus.flush_i || !freq || pop)
            starve_nxt = '0;
        else if (pipe_gnt && starve != SW'(STARVE_MAX))
            starve_nxt = starve + SW'(1);
    end

    assign bus.ll_ready_o   = (count != CW'(DEPTH));
    assign bus.ll_pending_o = freq;
    assign bus.wb_stall_o   = preq & force_fifo;

    always_ff @(posedge clk) begin
        if (push)
            begin
                fifo_dest[wr_ptr] <= bus.ll_wdest_i;
                fifo_data[wr_ptr] <= bus.ll_wdata_i;
            end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            starve <= starve_nxt;
            if (bus.flush_i) begin
                // A beat accepted this cycle is dropped along with the contents.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Regfile port: address/data hold their last value in idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rf_wen_o   <= 1'b0;
            bus.rf_waddr_o <= 5'd0;
            bus.rf_wdata_o <= '0;
        end else begin
            bus.rf_wen_o <= wen_nxt;
            if (wen_nxt) begin
                bus.rf_waddr_o <= waddr_nxt;
                bus.rf_wdata_o <= wdata_nxt;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_cnt <= 32'd0;
        else if (bus.wb_stall_o)
            perf_cnt <= perf_cnt + 32'd1;
    end
    assign bus.perf_stall_cnt_o = perf_cnt;
`else
    assign bus.perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_210247_wb_arbiter.sv
// Bench for the regfile write-port arbiter: directed cycles push expected regfile
// writes into a scoreboard queue; a negedge monitor pops and compares each write.
module tb_ysyx_210247_wb_arbiter;
    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

`ifdef WB_ARB_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    wr_t  exp_q[$];
    wr_t  mon_e;

    ysyx_210247_wb_arbiter_if #(.XLEN(64)) bus ();

    ysyx_210247_wb_arbiter #(.XLEN(64), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [63:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input logic wv, input logic wen, input logic [4:0] wd,
                          input logic [63:0] wdat, input logic lv, input logic [4:0] ld,
                          input logic [63:0] ldat, input logic fl);
        bus.wb_valid_i = wv;
        bus.wb_wen_i   = wen;
        bus.wb_wdest_i = wd;
        bus.wb_wdata_i = wdat;
        bus.ll_valid_i = lv;
        bus.ll_wdest_i = ld;
        bus.ll_wdata_i = ldat;
        bus.flush_i    = fl;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0);
        repeat (n) next_cyc();
    endtask

    // Monitor: every regfile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rf_wen_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rf_write_unexpected: got addr %0d data %0h, required no write",
                         bus.rf_waddr_o, bus.rf_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_waddr_o !== mon_e.a || bus.rf_wdata_o !== mon_e.d) begin
                    n_err++;
                    $display("FAIL rf_write: got addr %0d data %0h, required addr %0d data %0h",
                             bus.rf_waddr_o, bus.rf_wdata_o, mon_e.a, mon_e.d);
                end
            end
        end
    end

    logic [4:0]  bd   [4];
    logic [63:0] bdat [4];
    int          beat, fi, k;
    logic        st;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_in(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_wen",   bus.rf_wen_o,         0);
        chk("rst_rf_waddr", bus.rf_waddr_o,       0);
        chk("rst_rf_wdata", bus.rf_wdata_o,       0);
        chk("rst_ll_ready", bus.ll_ready_o,       1);
        chk("rst_pending",  bus.ll_pending_o,     0);
        chk("rst_stall",    bus.wb_stall_o,       0);
        chk("rst_perf",     bus.perf_stall_cnt_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // ---- bypass: empty FIFO, no pipeline request ----
        set_in(0, 0, 5'd0, 64'd0, 1, 5'd5, 64'hAB, 0);
        @(negedge clk);
        chk("byp_ready", bus.ll_ready_o, 1);
        chk("byp_stall", bus.wb_stall_o, 0);
        expect_wr(5'd5, 64'hAB);
        next_cyc();
        set_in(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0);
        @(negedge clk);
        chk("byp_pending", bus.ll_pending_o, 0);
        chk("byp_rf_wen",  bus.rf_wen_o,     1);
        next_cyc();
        idle(2);

        // ---- contention / starvation limit ----
        set_in(1, 1, 5'd3, 64'h100, 1, 5'd7, 64'h11, 0);
        @(negedge clk);
        chk("sv_stall0", bus.wb_stall_o, 0);
        expect_wr(5'd3, 64'h100);
        next_cyc();
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 1, 5'd3, 64'h100 + 64'(i), 0, 5'd0, 64'd0, 0);
            @(negedge clk);
            chk("sv_stall_pipe", bus.wb_stall_o,   0);
            chk("sv_pending",    bus.ll_pending_o, 1);
            expect_wr(5'd3, 64'h100 + 64'(i));
            next_cyc();
        end
        set_in(1, 1, 5'd3, 64'h105, 0, 5'd0, 64'd0, 0);
        @(negedge clk);
        chk("sv_stall_forced", bus.wb_stall_o, 1);
        expect_wr(5'd7, 64'h11);
        next_cyc();
        @(negedge clk);
        chk("sv_stall_resume", bus.wb_stall_o,   0);
        chk("sv_pending_done", bus.ll_pending_o, 0);
        expect_wr(5'd3, 64'h105);
        next_cyc();
        idle(1);
        chk("sv_perf", bus.perf_stall_cnt_o, PERF_ON ? 64'd1 : 64'd0);

        // ---- full FIFO under continuous pipeline traffic ----
        bd[0] = 5'd8;  bdat[0] = 64'hA1;
        bd[1] = 5'd9;  bdat[1] = 64'hA2;
        bd[2] = 5'd10; bdat[2] = 64'hA3;
        bd[3] = 5'd0;  bdat[3] = 64'h0;
        beat = 0;
        fi   = 0;
        k    = 0;
        for (int c = 0; c < 17; c++) begin
            st = (c == 5) || (c == 10) || (c == 15);
            set_in(1, 1, 5'd3, 64'h200 + 64'(k), beat < 3, bd[beat], bdat[beat], 0);
            @(negedge clk);
            chk("full_stall", bus.wb_stall_o, st);
            if (c <= 6)
                chk("full_ready", bus.ll_ready_o, (c < 2) || (c == 6));
            if (st) begin
                expect_wr(bd[fi], bdat[fi]);
                fi++;
            end else begin
                expect_wr(5'd3, 64'h200 + 64'(k));
                k++;
            end
            if (beat < 3 && bus.ll_ready_o) beat++;
            next_cyc();
        end
        idle(1);
        chk("full_pending_end", bus.ll_pending_o, 0);
        chk("full_perf", bus.perf_stall_cnt_o, PERF_ON ? 64'd4 : 64'd0);

        // ---- flush with two buffered entries ----
        set_in(1, 1, 5'd3, 64'h300, 1, 5'd11, 64'hB1, 0);
        @(negedge clk);
        expect_wr(5'd3, 64'h300);
        next_cyc();
        set_in(1, 1, 5'd3, 64'h301, 1, 5'd12, 64'hB2, 0);
        @(negedge clk);
        expect_wr(5'd3, 64'h301);
        next_cyc();
        set_in(1, 1, 5'd4, 64'h302, 0, 5'd0, 64'd0, 1);
        @(negedge clk);
        chk("fl_pending_before", bus.ll_pending_o, 1);
        chk("fl_ready_full",     bus.ll_ready_o,   0);
        chk("fl_stall",          bus.wb_stall_o,   0);
        expect_wr(5'd4, 64'h302);
        next_cyc();
        set_in(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0);
        @(negedge clk);
        chk("fl_pending_after", bus.ll_pending_o, 0);
        chk("fl_ready_after",   bus.ll_ready_o,   1);
        next_cyc();
        idle(4);

        // flush with an ll beat on an empty FIFO: accepted and dropped
        set_in(0, 0, 5'd0, 64'd0, 1, 5'd14, 64'hB4, 1);
        @(negedge clk);
        chk("fl_ll_ready", bus.ll_ready_o, 1);
        next_cyc();
        set_in(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0);
        @(negedge clk);
        chk("fl_ll_pending", bus.ll_pending_o, 0);
        chk("fl_ll_no_wen",  bus.rf_wen_o,     0);
        next_cyc();
        idle(2);

        // ---- x0 handling ----
        set_in(1, 1, 5'd3, 64'h400, 1, 5'd0, 64'hC0, 0);
        @(negedge clk);
        expect_wr(5'd3, 64'h400);
        next_cyc();
        set_in(1, 1, 5'd3, 64'h401, 0, 5'd0, 64'd0, 0);
        @(negedge clk);
        chk("x0_pending_head", bus.ll_pending_o, 1);
        chk("x0_stall_head",   bus.wb_stall_o,   0);
        expect_wr(5'd3, 64'h401);
        next_cyc();
        set_in(1, 1, 5'd0, 64'h402, 0, 5'd0, 64'd0, 0);
        @(negedge clk);
        chk("x0_pending_gone", bus.ll_pending_o, 0);
        chk("x0_wb_stall",     bus.wb_stall_o,   0);
        next_cyc();
        set_in(1, 0, 5'd6, 64'h403, 0, 5'd0, 64'd0, 0);
        @(negedge clk);
        chk("x0_wb_wen_no_write", bus.rf_wen_o, 0);
        next_cyc();
        set_in(0, 0, 5'd0, 64'd0, 1, 5'd0, 64'hC1, 0);
        @(negedge clk);
        chk("x0_ll_no_write", bus.rf_wen_o, 0);
        next_cyc();
        idle(3);
        chk("x0_perf", bus.perf_stall_cnt_o, PERF_ON ? 64'd4 : 64'd0);

        // every expected write must have appeared
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_210247_wb_arbiter.md
Name: ysyx_210247_wb_arbiter

Overview:
Arbitrates the single integer register-file write port between two sources: the in-order WB stage write and results returned by long-latency units (mul/div), which complete out of band. Long-latency results are buffered in a small FIFO. A starvation limit guarantees that the buffered results drain. The block sits between the WB stage / long-latency return bus and the regfile write port, and drives the WB-stage stall.

Parameters:
XLEN, 64, data width
DEPTH, 2, long-latency holding FIFO entries (power of 2, >=2)
STARVE_MAX, 4, max consecutive pipeline wins while FIFO non-empty before FIFO is forced

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
wb_valid_i  in  1  WB stage holds a valid instruction
wb_wen_i  in  1  WB write enable (already exception-masked)
wb_wdest_i  in  5  WB destination register
wb_wdata_i  in  XLEN  WB write data
wb_stall_o  out  1  WB write not taken this cycle; WB must hold
ll_valid_i  in  1  long-latency result valid
ll_ready_o  out  1  arbiter can accept a long-latency result
ll_wdest_i  in  5  long-latency destination
ll_wdata_i  in  XLEN  long-latency data
flush_i  in  1  pipeline flush from WB (exception/trap)
rf_wen_o  out  1  regfile write enable (registered)
rf_waddr_o  out  5  regfile write address (registered)
rf_wdata_o  out  XLEN  regfile write data (registered)
ll_pending_o  out  1  FIFO non-empty
perf_stall_cnt_o  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers and count 0, starve counter 0, rf_wen_o/rf_waddr_o/rf_wdata_o = 0, perf counter 0.
- Pipeline request: preq = wb_valid_i & wb_wen_i & (wb_wdest_i != 0). Writes to x0 never use the port and never stall.
- FIFO head request: freq = count != 0. A head with dest 0 is popped without any write, and the port stays free for the pipeline that cycle.
- Grant, evaluated per cycle:
  - freq & starve == STARVE_MAX -> FIFO wins; wb_stall_o = preq.
  - Otherwise, preq -> pipeline wins; wb_stall_o = 0.
  - Otherwise, freq -> FIFO wins.
  - Otherwise, ll bypass: ll_valid_i & count==0 & !flush_i -> incoming result is written directly and not enqueued.
- Starve counter:
  - +1 (saturating at STARVE_MAX) when pipeline wins while freq.
  - Reset to 0 on FIFO grant or when count==0.
- Regfile port: winner's addr/data registered into rf_* on the next clk edge, so latency is 1 cycle. rf_wen_o = 0 in idle cycles; rf_waddr_o/rf_wdata_o hold their last value.
- ll_ready_o = (count != DEPTH), combinational from count. There is no push when full. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- An ll beat accepted while a non-empty FIFO is draining is enqueued behind existing entries (FIFO order preserved). WAW ordering versus pipeline writes is guaranteed by the issue scoreboard, not by this block.
- flush_i:
  - FIFO contents discarded and count forced to 0 at the clock edge.
  - An ll beat presented the same cycle is accepted (ll_ready_o follows count) and dropped.
  - A pipeline write in the flush cycle is still performed (wb_wen_i is already masked by WB).
  - A FIFO grant in the flush cycle still writes; the flush affects only the next state.
  - Starve counter cleared.
- wb_stall_o is combinational and asserts only in forced-FIFO cycles with preq.
- ll_pending_o = (count != 0).

Optional Feature:
WB_ARB_PERF_EN: when defined, perf_stall_cnt_o is a 32-bit wrapping counter incremented every cycle wb_stall_o=1; it is cleared only by reset and is unaffected by flush. When undefined, the port stays present and is tied to 0, with no counter flops.

Test Plan:
- Reset then idle -> rf_wen_o=0, ll_ready_o=1, ll_pending_o=0, wb_stall_o=0.
- Bypass: empty FIFO, no preq; ll beat dest=5 data=0xAB -> next cycle rf_wen_o=1, waddr=5, wdata=0xAB; count stays 0.
- Contention with STARVE_MAX=4:
  - Continuous preq (dest=3); one ll beat (dest=7, 0x11) accepted into the FIFO.
  - Pipeline writes for 4 cycles, then 5th cycle wb_stall_o=1 and rf writes 7/0x11 next cycle.
  - Next cycle the pipeline resumes with no stall.
- Full FIFO: DEPTH=2 with preq held busy; push 2 beats -> ll_ready_o=0. Third beat held by source until a FIFO grant pops one; order of writes is beat1, beat2, beat3.
- Flush: FIFO holds 2 entries; assert flush_i with preq dest=4 -> next cycle rf writes dest 4; count=0; no buffered entry is ever written.
- x0 handling: ll beat dest=0 queued behind busy pipeline -> popped without rf_wen_o; pipeline write dest=0 -> no rf_wen_o, no stall. With WB_ARB_PERF_EN, 1 forced-stall cycle -> perf_stall_cnt_o=1.
